// File: rtl/spi_responder_if.sv
// Link and core-side handshake signals of the serial peripheral responder.
// The slave modport is the responder's view; the master modport is the view of
// whatever drives the link and plays the compute core.
interface spi_responder_if #(
    parameter int NssWidth      = 3,
    parameter int RequestWidth  = 68,
    parameter int ResponseWidth = 32
);
    logic [NssWidth-1:0]      i_nss;
    logic                     i_mosi;
    logic                     o_miso;
    logic                     o_req_valid;
    logic [RequestWidth-1:0]  o_req_data;
    logic                     i_req_ready;
    logic                     i_rsp_valid;
    logic [ResponseWidth-1:0] i_rsp_data;
    logic                     o_rsp_ready;
    logic                     o_busy;

    modport slave (
        input  i_nss,
        input  i_mosi,
        input  i_req_ready,
        input  i_rsp_valid,
        input  i_rsp_data,
        output o_miso,
        output o_req_valid,
        output o_req_data,
        output o_rsp_ready,
        output o_busy
    );

    modport master (
        output i_nss,
        output i_mosi,
        output i_req_ready,
        output i_rsp_valid,
        output i_rsp_data,
        input  o_miso,
        input  o_req_valid,
        input  o_req_data,
        input  o_rsp_ready,
        input  o_busy
    );
endinterface

// File: rtl/spi_responder.sv
// Slave-side endpoint of the serial peripheral link. A start bit opens a frame,
// the request is shifted in LSB first, handed to a compute core via valid/ready,
// and the core's result goes back out as a start bit followed by the result LSB
// first. Dropping this slave's select line at any point returns to IDLE.
module spi_responder #(
    parameter int NssPosition   = 0,
    parameter int NssWidth      = 3,
    parameter int RequestWidth  = 68,
    parameter int ResponseWidth = 32
) (
    input  logic           i_clock,
    input  logic           i_reset,
    spi_responder_if.slave bus
);

    localparam int MaxWidth = (RequestWidth > ResponseWidth) ? RequestWidth : ResponseWidth;
    localparam int CntWidth = (MaxWidth > 1) ? $clog2(MaxWidth) : 1;
    localparam int NssIndex = (NssPosition < NssWidth) ? NssPosition : 0;

    localparam logic [CntWidth-1:0] RxLast = CntWidth'(RequestWidth - 1);
    localparam logic [CntWidth-1:0] TxLast = CntWidth'(ResponseWidth - 1);

    typedef enum logic [2:0] {
        IDLE,
        RX,
        REQ,
        WAIT,
        START,
        TX
    } state_e;

    state_e                   state_q, state_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d;
    logic [RequestWidth-1:0]  req_data_q, req_data_d;
    logic [ResponseWidth-1:0] shift_q, shift_d;
    logic                     sel;

    assign sel = ~bus.i_nss[NssIndex];

    // Next-state, counter and datapath updates; an abort always wins over progress.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_data_d = req_data_q;
        shift_d    = shift_q;

        case (state_q)
            IDLE: begin
                if (sel && bus.i_mosi) begin
                    state_d = RX;
                    cnt_d   = '0;
                end
            end

            RX: begin
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // Shifting in from the top leaves the first wire bit in bit 0.
                    req_data_d = {bus.i_mosi, req_data_q[RequestWidth-1:1]};
                    if (cnt_q == RxLast) begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            REQ: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (bus.i_req_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (bus.i_rsp_valid) begin
                    shift_d = bus.i_rsp_data;
                    state_d = START;
                end
            end

            START: begin
                if (!sel) begin
                    state_d = IDLE;
                end else begin
                    state_d = TX;
                    cnt_d   = '0;
                end
            end

            TX: begin
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == TxLast) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_data_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_data_q <= req_data_d;
            shift_q    <= shift_d;
        end
    end

    // Outputs decoded purely from registered state, so miso never glitches with inputs.
    always_comb begin
        bus.o_miso      = 1'b0;
        bus.o_req_valid = (state_q == REQ);
        bus.o_rsp_ready = (state_q == WAIT);
        bus.o_busy      = (state_q != IDLE);
        bus.o_req_data  = req_data_q;
        if (state_q == START) begin
            bus.o_miso = 1'b1;
        end else if (state_q == TX) begin
            bus.o_miso = shift_q[0];
        end
    end

endmodule
